// File: rtl/quiz_countdown_timer.sv
// Two-phase quiz countdown timer: a grab window after Start, an answer window
// after a contestant is accepted, BCD display, warning blinker and expiry flags.
module quiz_countdown_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int GRAB_SEC      = 30,
  parameter int ANSWER_SEC    = 60,
  parameter int WARN_SEC      = 5,
  parameter int BLINK_HALF    = 12_500_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  input  logic       Answer,
  input  logic       Pause,
  input  logic       Clear,
  output logic [3:0] TimerH,
  output logic [3:0] TimerL,
  output logic [1:0] Phase,
  output logic       LED_Warn,
  output logic       Buzzer,
  output logic       TimeOver,
  output logic       TimeOver_Pulse
);

  localparam int MIN_SEC = (GRAB_SEC < ANSWER_SEC) ? GRAB_SEC : ANSWER_SEC;
  localparam int SEC_W   = $clog2(TICKS_PER_SEC);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  localparam logic [SEC_W-1:0]   SEC_MAX   = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);
  localparam logic [3:0] GRAB_T   = 4'(GRAB_SEC / 10);
  localparam logic [3:0] GRAB_U   = 4'(GRAB_SEC % 10);
  localparam logic [3:0] ANSWER_T = 4'(ANSWER_SEC / 10);
  localparam logic [3:0] ANSWER_U = 4'(ANSWER_SEC % 10);
  localparam logic [6:0] WARN_LIM = 7'(WARN_SEC);

  // Reject parameter values the counters and BCD loads cannot represent
  if (TICKS_PER_SEC < 2) begin : gChkTicks
    $error("TICKS_PER_SEC must be at least 2");
  end
  if (GRAB_SEC < 1 || GRAB_SEC > 99) begin : gChkGrab
    $error("GRAB_SEC must be in 1..99");
  end
  if (ANSWER_SEC < 1 || ANSWER_SEC > 99) begin : gChkAnswer
    $error("ANSWER_SEC must be in 1..99");
  end
  if (WARN_SEC < 0 || WARN_SEC > MIN_SEC - 1) begin : gChkWarn
    $error("WARN_SEC must be in 0..min(GRAB_SEC,ANSWER_SEC)-1");
  end
  if (BLINK_HALF < 1) begin : gChkBlink
    $error("BLINK_HALF must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRAB    = 2'b01,
    ANSWER  = 2'b10,
    EXPIRED = 2'b11
  } phase_t;

  phase_t             phase_q, phase_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         units_q, units_d;
  logic [SEC_W-1:0]   secCnt_q, secCnt_d;
  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               warnAct_q, warnAct_d;
  logic               led_q, led_d;
  logic               buzz_q, buzz_d;
  logic               timeOver_q, timeOver_d;
  logic               pulse_q, pulse_d;

  logic       running;
  logic       tick;
  logic       warnNow;
  logic [6:0] countBin;

  // Next-state: control priority Clear > Start > Answer > second tick, then
  // the warning/expiry indicators derived from where the count is heading.
  // The second prescaler doubles as the expiry-buzzer timer while EXPIRED.
  always_comb begin
    phase_d    = phase_q;
    tens_d     = tens_q;
    units_d    = units_q;
    secCnt_d   = secCnt_q;
    blinkCnt_d = blinkCnt_q;
    warnAct_d  = warnAct_q;
    led_d      = led_q;
    buzz_d     = buzz_q;
    running    = (phase_q == GRAB) || (phase_q == ANSWER);
    tick       = running && !Pause && (secCnt_q == SEC_MAX);

    if (Clear) begin
      phase_d  = IDLE;
      tens_d   = 4'd0;
      units_d  = 4'd0;
      secCnt_d = '0;
    end else if (Start) begin
      phase_d  = GRAB;
      tens_d   = GRAB_T;
      units_d  = GRAB_U;
      secCnt_d = '0;
    end else if (Answer && (phase_q == GRAB)) begin
      phase_d  = ANSWER;
      tens_d   = ANSWER_T;
      units_d  = ANSWER_U;
      secCnt_d = '0;
    end else if (tick) begin
      secCnt_d = '0;
      if (units_q == 4'd0) begin
        units_d = 4'd9;
        tens_d  = tens_q - 4'd1;
      end else begin
        units_d = units_q - 4'd1;
      end
      if ((tens_q == 4'd0) && (units_q == 4'd1)) begin
        phase_d = EXPIRED;
      end
    end else if (running && !Pause) begin
      secCnt_d = secCnt_q + SEC_W'(1);
    end else if ((phase_q == EXPIRED) && (secCnt_q != SEC_MAX)) begin
      secCnt_d = secCnt_q + SEC_W'(1);
    end

    countBin   = 7'(tens_d) * 7'd10 + 7'(units_d);
    warnNow    = ((phase_d == GRAB) || (phase_d == ANSWER)) &&
                 (countBin != 7'd0) && (countBin <= WARN_LIM);
    timeOver_d = (phase_d == EXPIRED);
    pulse_d    = (phase_d == EXPIRED) && (phase_q != EXPIRED);

    if (phase_d == EXPIRED) begin
      warnAct_d  = 1'b0;
      led_d      = 1'b0;
      blinkCnt_d = '0;
      if (phase_q != EXPIRED) begin
        buzz_d = 1'b1;
      end else if (secCnt_q == SEC_MAX) begin
        buzz_d = 1'b0;
      end
    end else if (!warnNow) begin
      warnAct_d  = 1'b0;
      led_d      = 1'b0;
      buzz_d     = 1'b0;
      blinkCnt_d = '0;
    end else if (!warnAct_q) begin
      warnAct_d  = 1'b1;
      led_d      = 1'b1;
      buzz_d     = 1'b1;
      blinkCnt_d = '0;
    end else if (!Pause) begin
      if (blinkCnt_q == BLINK_MAX) begin
        blinkCnt_d = '0;
        led_d      = ~led_q;
        buzz_d     = ~buzz_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BLINK_W'(1);
      end
    end
  end

  // State and registered outputs, cleared asynchronously by RSTn
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      phase_q    <= IDLE;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      secCnt_q   <= '0;
      blinkCnt_q <= '0;
      warnAct_q  <= 1'b0;
      led_q      <= 1'b0;
      buzz_q     <= 1'b0;
      timeOver_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      secCnt_q   <= secCnt_d;
      blinkCnt_q <= blinkCnt_d;
      warnAct_q  <= warnAct_d;
      led_q      <= led_d;
      buzz_q     <= buzz_d;
      timeOver_q <= timeOver_d;
      pulse_q    <= pulse_d;
    end
  end

  assign Phase          = phase_q;
  assign TimerH         = tens_q;
  assign TimerL         = units_q;
  assign LED_Warn       = led_q;
  assign Buzzer         = buzz_q;
  assign TimeOver       = timeOver_q;
  assign TimeOver_Pulse = pulse_q;

endmodule

// File: doc/quiz_countdown_timer.md
Name: quiz_countdown_timer

Overview:
- Parametrised two-phase countdown timer for the quiz-responder datapath.
- Runs a "grab" window after the host starts a round. When a contestant buzzes in, it runs an "answer" window.
- Drives a two-digit BCD display, a warning blinker/buzzer near expiry, and overtime flags to the lockout logic.
- Single clock domain: every register is clocked by CLK. Second and blink timing come from internal prescalers, not derived clocks.

Parameters:
- TICKS_PER_SEC, 50_000_000, CLK cycles per displayed second (≥2).
- GRAB_SEC, 30, grab-window length in seconds (1..99).
- ANSWER_SEC, 60, answer-window length in seconds (1..99).
- WARN_SEC, 5, warning threshold in seconds (0..min(GRAB_SEC,ANSWER_SEC)-1; 0 disables warning).
- BLINK_HALF, 12_500_000, CLK cycles per half-period of warning blink (≥1).

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse: begin/restart grab window.
- Answer  in  1  single-cycle pulse: contestant accepted, begin answer window.
- Pause  in  1  level: freeze countdown and blink.
- Clear  in  1  single-cycle pulse: return to IDLE.
- TimerH  out  4  BCD tens digit.
- TimerL  out  4  BCD units digit.
- Phase  out  2  00 IDLE, 01 GRAB, 10 ANSWER, 11 EXPIRED.
- LED_Warn  out  1  blinking warning indicator.
- Buzzer  out  1  warning/expiry buzzer.
- TimeOver  out  1  level, high while EXPIRED.
- TimeOver_Pulse  out  1  one-cycle strobe on entry to EXPIRED.

Behaviour:
Elaboration and reset
- Illegal parameter values cause an elaboration-time error.
- Reset (asynchronous, active-low): Phase=IDLE, TimerH=TimerL=0, prescalers=0, all 1-bit outputs 0.

Control priority (per edge)
- Clear > Start > Answer > second tick.
- Clear, Start and Answer are acted on even while Pause=1.

State machine
- IDLE: display 00. Start -> GRAB; load BCD(GRAB_SEC); second prescaler=0. Answer ignored.
- GRAB: on second tick, BCD-decrement. Answer -> ANSWER; load BCD(ANSWER_SEC); second prescaler=0. Start reloads BCD(GRAB_SEC).
- ANSWER: on second tick, BCD-decrement. Answer ignored. Start -> GRAB with reload.
- EXPIRED: display 00; TimeOver=1. Start -> GRAB with reload. Clear -> IDLE. Answer ignored.
- Any state: Clear -> IDLE, display 00, all outputs 0.

Second tick
- Second prescaler counts 0..TICKS_PER_SEC-1 only in GRAB/ANSWER with Pause=0.
- Tick = prescaler at TICKS_PER_SEC-1; prescaler wraps to 0 on that edge.
- First decrement occurs exactly TICKS_PER_SEC cycles after the load edge.
- BCD decrement: units 0 -> 9 with tens-1; otherwise units-1. No binary intermediate on display.

Expiry
- A tick that takes the count 01 -> 00 also moves Phase to EXPIRED on the same edge.
- TimeOver and TimeOver_Pulse are registered with Phase: high the cycle after that edge.
- TimeOver_Pulse lasts exactly 1 cycle.

Warning
- Active when Phase is GRAB/ANSWER and 0 < count ≤ WARN_SEC.
- On entry, LED_Warn=Buzzer=1 and the blink prescaler clears. Both toggle every BLINK_HALF cycles; Pause freezes them.
- On leaving warning (reload, Answer, Clear), both go 0 and the blink prescaler clears.

Expiry buzzer
- In EXPIRED, Buzzer=1 steadily for TICKS_PER_SEC cycles, then 0. LED_Warn=0.
- Pause does not affect the expiry buzzer.

Simultaneous events and Pause
- Answer on a tick edge: the reload wins and no decrement occurs.
- Start on the expiry edge: GRAB reload wins; no TimeOver_Pulse.
- Pause=1: count, second prescaler and blink prescaler hold their values.

Test Plan:
Bench parameters: TICKS_PER_SEC=10, GRAB_SEC=12, ANSWER_SEC=5, WARN_SEC=3, BLINK_HALF=2.
- Reset, then Start -> Phase=01, display 12; after 10 cycles 11; after 30 cycles 09 (units wrap, tens decrement).
- Start, then no Answer for 120 cycles -> 03 at cycle 90 with LED_Warn toggling every 2 cycles. Display 00 and Phase=11 at cycle 120. TimeOver_Pulse high 1 cycle, TimeOver held. Buzzer high 10 cycles then 0.
- Start, then Answer at cycle 25 -> Phase=10, display 05. Decrement 10 cycles later. Warning from 03. Expiry 50 cycles after Answer.
- Answer asserted on a tick edge in GRAB -> display 05 with no decrement. Second Answer in ANSWER -> ignored.
- Pause held 37 cycles mid-GRAB at display 10 -> display, prescaler and blink frozen; countdown resumes with no lost or extra tick.
- RSTn pulsed low mid-ANSWER, and separately Clear in EXPIRED -> Phase=00, display 00, all outputs 0 immediately (reset) / next edge (Clear).
